// File: rtl/icap_sched_pkg.sv
// Shared types and ICAP command words for the ICAP scheduler.
// Command words are held in natural bit order; the byte bit-swap is applied at the ICAP pins.
package icap_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BOOT,
        WR_RDHDR,
        RD_TURN,
        RD_WAIT,
        RD_BACK,
        DESYNC
    } state_t;

    localparam logic [31:0] W_DUMMY      = 32'hFFFF_FFFF;
    localparam logic [31:0] W_SYNC       = 32'hAA99_5566;
    localparam logic [31:0] W_NOOP       = 32'h2000_0000;
    localparam logic [31:0] W_HDR_WBSTAR = 32'h3002_0001;
    localparam logic [31:0] W_HDR_CMD    = 32'h3000_8001;
    localparam logic [31:0] W_CMD_IPROG  = 32'h0000_000F;
    localparam logic [31:0] W_CMD_DESYNC = 32'h0000_000D;
    localparam logic [31:0] W_RDHDR_BASE = 32'h2800_0001;
    localparam int          RDHDR_ADDR_LSB = 13;

    function automatic logic [7:0] bitswap_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = b[7-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_bitswap.sv
// Per-byte bit reversal between logical word order and the ICAP pin order.
module icap_bitswap
    import icap_sched_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign dout[gi*8 +: 8] = bitswap_byte(din[gi*8 +: 8]);
    end
endmodule

// File: rtl/icap_sched.sv
// ICAP arbiter/sequencer: round-robin between register readback (A) and
// multiboot reboot (B), each emitted as a complete registered command stream.
module icap_sched
    import icap_sched_pkg::*;
#(
    parameter int          RD_TIMEOUT  = 1024,
    parameter logic [31:0] RD_ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [4:0]  rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_err,
    input  logic        boot_req,
    input  logic [31:0] boot_addr,
    output logic        boot_ack,
    output logic        busy,
    output logic        icap_csb,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    input  logic [31:0] icap_o,
    input  logic        icap_busy
);
    localparam int            TW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(RD_TIMEOUT);

    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          rr_last_b_reg, rr_last_b_next;
    logic [4:0]    rd_addr_reg;
    logic [31:0]   boot_addr_reg;
    logic          grant_rd, grant_boot, tmo_hit;
    logic          csb_next, rdwrb_next, word_wr;
    logic [31:0]   word_sel, word_swapped, o_restored;

    assign grant_rd   = (state_reg == IDLE) && rd_req && (!boot_req || rr_last_b_reg);
    assign grant_boot = (state_reg == IDLE) && boot_req && !grant_rd;
    assign tmo_hit    = (tmo_reg == TMO_MAX);
    assign busy       = (state_reg != IDLE);

    icap_bitswap u_swap_i (.din(word_sel), .dout(word_swapped));
    icap_bitswap u_swap_o (.din(icap_o),   .dout(o_restored));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            tmo_reg       <= '0;
            rr_last_b_reg <= 1'b1;
            rd_addr_reg   <= '0;
            boot_addr_reg <= '0;
            icap_csb      <= 1'b1;
            icap_rdwrb    <= 1'b0;
            icap_i        <= '0;
            rd_ack        <= 1'b0;
            boot_ack      <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            rd_err        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            tmo_reg       <= tmo_next;
            rr_last_b_reg <= rr_last_b_next;
            if (grant_rd)   rd_addr_reg   <= rd_addr;
            if (grant_boot) boot_addr_reg <= boot_addr;
            icap_csb   <= csb_next;
            icap_rdwrb <= rdwrb_next;
            if (word_wr) icap_i <= word_swapped;
            rd_ack   <= grant_rd;
            boot_ack <= grant_boot;
            rd_valid <= (state_reg == DESYNC) && (idx_reg == 3'd3);
            // A returned word takes priority over a timeout landing in the same cycle
            if (state_reg == RD_WAIT && !icap_busy) begin
                rd_data <= o_restored;
                rd_err  <= 1'b0;
            end else if (state_reg == RD_WAIT && tmo_hit) begin
                rd_data <= RD_ERR_DATA;
                rd_err  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_last_b_next = rr_last_b_reg;
        tmo_next       = '0;
        unique case (state_reg)
            IDLE: begin
                if (grant_rd) begin
                    state_next     = WR_RDHDR;
                    rr_last_b_next = 1'b0;
                end else if (grant_boot) begin
                    state_next     = WR_BOOT;
                    rr_last_b_next = 1'b1;
                end
            end
            WR_BOOT:  if (idx_reg == 3'd7) state_next = IDLE;
            WR_RDHDR: if (idx_reg == 3'd6) state_next = RD_TURN;
            RD_TURN:  state_next = RD_WAIT;
            RD_WAIT: begin
                if (!icap_busy || tmo_hit) state_next = RD_BACK;
                tmo_next = tmo_hit ? tmo_reg : tmo_reg + TW'(1);
            end
            RD_BACK:  state_next = DESYNC;
            DESYNC:   if (idx_reg == 3'd3) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        idx_next = (state_next != state_reg) ? 3'd0 : idx_reg + 3'd1;
    end

    // RDWRB only moves in the turnaround states, where CSB is being driven high
    always_comb begin
        csb_next   = 1'b1;
        rdwrb_next = icap_rdwrb;
        word_wr    = 1'b0;
        word_sel   = W_NOOP;
        unique case (state_reg)
            WR_BOOT: begin
                csb_next   = 1'b0;
                rdwrb_next = 1'b0;
                word_wr    = 1'b1;
                case (idx_reg)
                    3'd0:    word_sel = W_DUMMY;
                    3'd1:    word_sel = W_SYNC;
                    3'd3:    word_sel = W_HDR_WBSTAR;
                    3'd4:    word_sel = boot_addr_reg;
                    3'd5:    word_sel = W_HDR_CMD;
                    3'd6:    word_sel = W_CMD_IPROG;
                    default: word_sel = W_NOOP;
                endcase
            end
            WR_RDHDR: begin
                csb_next   = 1'b0;
                rdwrb_next = 1'b0;
                word_wr    = 1'b1;
                case (idx_reg)
                    3'd0:    word_sel = W_DUMMY;
                    3'd1:    word_sel = W_SYNC;
                    3'd4:    word_sel = W_RDHDR_BASE | (32'(rd_addr_reg) << RDHDR_ADDR_LSB);
                    default: word_sel = W_NOOP;
                endcase
            end
            RD_TURN: rdwrb_next = 1'b1;
            RD_WAIT: begin
                csb_next   = 1'b0;
                rdwrb_next = 1'b1;
            end
            RD_BACK: rdwrb_next = 1'b0;
            DESYNC: begin
                csb_next   = 1'b0;
                rdwrb_next = 1'b0;
                word_wr    = 1'b1;
                case (idx_reg)
                    3'd0:    word_sel = W_HDR_CMD;
                    3'd1:    word_sel = W_CMD_DESYNC;
                    default: word_sel = W_NOOP;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icap_sched.sv
// Scenario bench for icap_sched with a bus monitor and a simple ICAP read responder.
`timescale 1ns/1ps
module tb_icap_sched;
    localparam int RD_TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset, rd_req, boot_req, icap_busy;
    logic        rd_ack, rd_valid, rd_err, boot_ack, busy, icap_csb, icap_rdwrb;
    logic [4:0]  rd_addr;
    logic [31:0] boot_addr, rd_data, icap_i, icap_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor-owned observations
    logic [31:0] wr_log[$];
    logic [31:0] raw_log[$];
    int          runs[$];
    int          grants[$];
    int          valid_cnt = 0;
    int          rdwrb_bad = 0;
    logic [31:0] v_data;
    logic        v_err;

    always #5 clk = ~clk;

    icap_sched #(.RD_TIMEOUT(RD_TIMEOUT), .RD_ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_ack(boot_ack),
        .busy(busy), .icap_csb(icap_csb), .icap_rdwrb(icap_rdwrb),
        .icap_i(icap_i), .icap_o(icap_o), .icap_busy(icap_busy)
    );

    function automatic logic [31:0] bswap(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[(i/8)*8 + 7 - (i%8)];
        return r;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        logic prev_rdwrb;
        int   run;
        prev_rdwrb = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (icap_rdwrb !== prev_rdwrb && icap_csb !== 1'b1) rdwrb_bad++;
            prev_rdwrb = icap_rdwrb;
            if (icap_csb === 1'b0 && icap_rdwrb === 1'b0) begin
                wr_log.push_back(bswap(icap_i));
                raw_log.push_back(icap_i);
            end
            if (icap_csb === 1'b0) run++;
            else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (rd_ack === 1'b1)   grants.push_back(0);
            if (boot_ack === 1'b1) grants.push_back(1);
            if (rd_valid === 1'b1) begin
                valid_cnt++;
                v_data = rd_data;
                v_err  = rd_err;
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_checks++; if (icap_csb !== 1'b1) begin n_fail++; $display("FAIL reset_csb: got %b, expected 1", icap_csb); end
        n_checks++; if (icap_rdwrb !== 1'b0) begin n_fail++; $display("FAIL reset_rdwrb: got %b, expected 0", icap_rdwrb); end
        n_checks++; if (icap_i !== 32'h0) begin n_fail++; $display("FAIL reset_icap_i: got %h, expected 0", icap_i); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h, expected 0", rd_data); end
        n_checks++;
        if ({rd_ack, rd_valid, rd_err, boot_ack, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b, expected 00000", {rd_ack, rd_valid, rd_err, boot_ack, busy});
        end
        reset = 1'b0;
        tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy); end
        $display("reset: checked");
    endtask

    task automatic test_reboot(input logic [31:0] addr, input logic [31:0] raw_addr_word);
        int g0, w0, r0, b0, n;
        logic [31:0] exp[8];
        exp = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
                addr, 32'h30008001, 32'h0000000F, 32'h20000000};
        g0 = grants.size(); w0 = wr_log.size(); r0 = runs.size(); b0 = rdwrb_bad;
        boot_addr = addr; boot_req = 1'b1;
        n = 0;
        while (grants.size() == g0 && n < 20) begin tick; n++; end
        boot_req = 1'b0; boot_addr = $urandom;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin tick; n++; end
        tick; tick;
        n_checks++;
        if (grants.size() != g0 + 1 || grants[g0] != 1) begin
            n_fail++; $display("FAIL boot_ack: got %0d grants, expected one B grant", grants.size() - g0);
        end
        n_checks++;
        if (runs.size() != r0 + 1 || runs[r0] != 8) begin
            n_fail++; $display("FAIL boot_csb_run: got %0d runs (first %0d), expected one run of 8",
                               runs.size() - r0, (runs.size() > r0) ? runs[r0] : -1);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (w0 + k >= wr_log.size() || wr_log[w0 + k] !== exp[k]) begin
                n_fail++; $display("FAIL boot_word%0d: got %h, expected %h", k,
                                   (w0 + k < wr_log.size()) ? wr_log[w0 + k] : 32'hx, exp[k]);
            end
        end
        n_checks++;
        if (w0 + 4 >= raw_log.size() || raw_log[w0 + 4] !== raw_addr_word) begin
            n_fail++; $display("FAIL boot_addr_pins: got %h, expected %h",
                               (w0 + 4 < raw_log.size()) ? raw_log[w0 + 4] : 32'hx, raw_addr_word);
        end
        n_checks++; if (rdwrb_bad != b0) begin n_fail++; $display("FAIL boot_rdwrb_rule: got %0d violations, expected 0", rdwrb_bad - b0); end
        $display("reboot: addr=%h words=%0d", addr, wr_log.size() - w0);
    endtask

    task automatic test_read(input logic [4:0] addr, input logic [31:0] val, input int dly);
        int g0, w0, r0, b0, v0, n;
        logic [31:0] exp[11];
        exp = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h20000000,
                32'h28000001 | ({27'd0, addr} << 13), 32'h20000000, 32'h20000000,
                32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};
        g0 = grants.size(); w0 = wr_log.size(); r0 = runs.size(); b0 = rdwrb_bad; v0 = valid_cnt;
        rd_addr = addr; rd_req = 1'b1;
        n = 0;
        while (grants.size() == g0 && n < 20) begin tick; n++; end
        rd_req = 1'b0; rd_addr = 5'($urandom_range(31, 0));
        n_checks++;
        if (grants.size() != g0 + 1 || grants[g0] != 0) begin
            n_fail++; $display("FAIL read_ack: got %0d grants, expected one A grant", grants.size() - g0);
        end
        n = 0;
        while (!(icap_csb === 1'b0 && icap_rdwrb === 1'b1) && n < 40) begin tick; n++; end
        n_checks++; if (n >= 40) begin n_fail++; $display("FAIL read_window: got no read phase, expected one within 40 cycles"); end
        repeat (dly) tick;
        icap_o = bswap(val); icap_busy = 1'b0;
        tick;
        icap_busy = 1'b1; icap_o = $urandom;
        n = 0;
        while (valid_cnt == v0 && n < 40) begin tick; n++; end
        tick; tick;
        n_checks++; if (valid_cnt != v0 + 1) begin n_fail++; $display("FAIL read_valid: got %0d pulses, expected 1", valid_cnt - v0); end
        n_checks++; if (v_data !== val) begin n_fail++; $display("FAIL read_data: got %h, expected %h", v_data, val); end
        n_checks++; if (v_err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b, expected 0", v_err); end
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (w0 + k >= wr_log.size() || wr_log[w0 + k] !== exp[k]) begin
                n_fail++; $display("FAIL read_word%0d: got %h, expected %h", k,
                                   (w0 + k < wr_log.size()) ? wr_log[w0 + k] : 32'hx, exp[k]);
            end
        end
        n_checks++;
        if (runs.size() != r0 + 3 || runs[r0] != 7 || runs[r0 + 1] != dly + 2 || runs[r0 + 2] != 4) begin
            n_fail++; $display("FAIL read_csb_runs: got %0d runs, expected 7,%0d,4", runs.size() - r0, dly + 2);
        end
        n_checks++; if (rdwrb_bad != b0) begin n_fail++; $display("FAIL read_rdwrb_rule: got %0d violations, expected 0", rdwrb_bad - b0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_end: got %b, expected 0", busy); end
        $display("read: addr=%0d data=%h err=%b", addr, v_data, v_err);
    endtask

    task automatic test_timeout(input logic [4:0] addr);
        int g0, w0, r0, v0, n;
        logic [31:0] des[4];
        des = '{32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};
        g0 = grants.size(); w0 = wr_log.size(); r0 = runs.size(); v0 = valid_cnt;
        icap_busy = 1'b1;
        rd_addr = addr; rd_req = 1'b1;
        n = 0;
        while (grants.size() == g0 && n < 20) begin tick; n++; end
        rd_req = 1'b0;
        n = 0;
        while (valid_cnt == v0 && n < RD_TIMEOUT + 60) begin tick; n++; end
        tick; tick;
        n_checks++; if (valid_cnt != v0 + 1) begin n_fail++; $display("FAIL tmo_valid: got %0d pulses, expected 1", valid_cnt - v0); end
        n_checks++; if (v_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL tmo_data: got %h, expected deadbeef", v_data); end
        n_checks++; if (v_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b, expected 1", v_err); end
        n_checks++;
        if (runs.size() != r0 + 3 || runs[r0 + 1] < RD_TIMEOUT || runs[r0 + 1] > RD_TIMEOUT + 2) begin
            n_fail++; $display("FAIL tmo_wait_len: got %0d, expected about %0d",
                               (runs.size() > r0 + 1) ? runs[r0 + 1] : -1, RD_TIMEOUT);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (w0 + 7 + k >= wr_log.size() || wr_log[w0 + 7 + k] !== des[k]) begin
                n_fail++; $display("FAIL tmo_desync%0d: got %h, expected %h", k,
                                   (w0 + 7 + k < wr_log.size()) ? wr_log[w0 + 7 + k] : 32'hx, des[k]);
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_end: got %b, expected 0", busy); end
        $display("timeout: data=%h err=%b wait=%0d", v_data, v_err, (runs.size() > r0 + 1) ? runs[r0 + 1] : -1);
    endtask

    task automatic test_contention;
        int g0, n;
        reset = 1'b1; rd_req = 1'b1; boot_req = 1'b1;
        rd_addr = 5'($urandom_range(31, 0)); boot_addr = $urandom;
        tick; tick;
        g0 = grants.size();
        reset = 1'b0;
        n = 0;
        while ((grants.size() < g0 + 3 || busy !== 1'b0) && n < 400) begin
            if (grants.size() >= g0 + 3) begin rd_req = 1'b0; boot_req = 1'b0; end
            icap_busy = !(icap_csb === 1'b0 && icap_rdwrb === 1'b1);
            tick; n++;
        end
        rd_req = 1'b0; boot_req = 1'b0; icap_busy = 1'b1;
        tick; tick;
        n_checks++; if (n >= 400) begin n_fail++; $display("FAIL cont_bound: got %0d grants, expected 3 within 400 cycles", grants.size() - g0); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (grants.size() <= g0 + k || grants[g0 + k] != (k % 2)) begin
                n_fail++; $display("FAIL cont_grant%0d: got %0d, expected %0d", k,
                                   (grants.size() > g0 + k) ? grants[g0 + k] : -1, k % 2);
            end
        end
        n_checks++; if (grants.size() != g0 + 3) begin n_fail++; $display("FAIL cont_count: got %0d grants, expected 3", grants.size() - g0); end
        $display("contention: grants=%0d", grants.size() - g0);
    endtask

    task automatic test_reset_mid;
        int g0, v0, n;
        g0 = grants.size(); v0 = valid_cnt;
        icap_busy = 1'b1;
        rd_addr = 5'd3; rd_req = 1'b1;
        n = 0;
        while (grants.size() == g0 && n < 20) begin tick; n++; end
        rd_req = 1'b0;
        n = 0;
        while (!(icap_csb === 1'b0 && icap_rdwrb === 1'b1) && n < 40) begin tick; n++; end
        tick; tick;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b, expected 1", busy); end
        reset = 1'b1;
        tick;
        n_checks++; if (icap_csb !== 1'b1) begin n_fail++; $display("FAIL mid_csb: got %b, expected 1", icap_csb); end
        n_checks++; if (icap_rdwrb !== 1'b0) begin n_fail++; $display("FAIL mid_rdwrb: got %b, expected 0", icap_rdwrb); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        reset = 1'b0;
        repeat (20) tick;
        n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL mid_no_valid: got %0d pulses, expected 0", valid_cnt - v0); end
        n_checks++; if (grants.size() != g0 + 1) begin n_fail++; $display("FAIL mid_no_ack: got %0d grants, expected 1", grants.size() - g0); end
        $display("reset_mid: aborted read, valid pulses=%0d", valid_cnt - v0);
    endtask

    initial begin : main
        logic [31:0] ra;
        reset = 1'b1; rd_req = 1'b0; boot_req = 1'b0; rd_addr = '0; boot_addr = '0;
        icap_busy = 1'b1; icap_o = '0;
        test_reset();
        test_reboot(32'h00400000, bswap(32'h00400000));
        test_reboot(32'h01020380, 32'h8040C001);
        test_read(5'd7, 32'h401079FC, 3);
        for (int k = 0; k < 3; k++) begin
            test_read(5'($urandom_range(31, 0)), $urandom, int'($urandom_range(6, 0)));
        end
        for (int k = 0; k < 2; k++) begin
            ra = $urandom;
            test_reboot(ra, bswap(ra));
        end
        test_timeout(5'd0);
        test_contention();
        test_reset_mid();
        test_read(5'd12, 32'h0123ABCD, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
